// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, gate hold/flush controls and statistics out.
// The master modport is the controller; the slave modport is the pipeline datapath.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic             ID_uses_rs1;
  logic             ID_uses_rs2;
  logic [4:0]       EX_rd;
  logic             EX_mem2reg;
  logic             EX_reg_wen;
  logic             MEM_is_branch;
  logic             MEM_cmp_res;
  logic             MEM_is_jal;
  logic             MEM_is_jalr;
  logic             MEM_mem_access;
  logic             dmem_ready;

  logic             pc_hold;
  logic             pc_redirect;
  logic             IF_ID_hold;
  logic             ID_EX_hold;
  logic             EX_MEM_hold;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             EX_MEM_flush;
  logic             MEM_WB_flush;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2,
    input  EX_rd, EX_mem2reg, EX_reg_wen,
    input  MEM_is_branch, MEM_cmp_res, MEM_is_jal, MEM_is_jalr, MEM_mem_access,
    input  dmem_ready,
    output pc_hold, pc_redirect,
    output IF_ID_hold, ID_EX_hold, EX_MEM_hold,
    output IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush,
    output mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    output ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2,
    output EX_rd, EX_mem2reg, EX_reg_wen,
    output MEM_is_branch, MEM_cmp_res, MEM_is_jal, MEM_is_jalr, MEM_mem_access,
    output dmem_ready,
    input  pc_hold, pc_redirect,
    input  IF_ID_hold, ID_EX_hold, EX_MEM_hold,
    input  IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush,
    input  mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: post-reset purge, dmem waits,
// MEM-stage redirects and load-use bubbles, plus stall/redirect statistics.
module pipeline_hazard_ctrl #(
  parameter int PURGE_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipeline_hazard_ctrl_if.master  hz
);

  localparam logic [1:0] ST_PURGE    = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  localparam int            PW         = (PURGE_CYCLES > 1) ? $clog2(PURGE_CYCLES) : 1;
  localparam logic [PW-1:0] PURGE_LAST = PW'(PURGE_CYCLES - 1);
  localparam logic [7:0]    TIMEOUT    = 8'(MEM_TIMEOUT);

  logic [1:0]    state_reg, state_next;
  logic [PW-1:0] purge_cnt_reg, purge_cnt_next;
  logic [7:0]    wait_cnt_reg, wait_cnt_next;
  logic          mem_err_reg, mem_err_next;

  logic rs1_hit, rs2_hit, load_use, redir, mem_stall;
  logic active, in_stall;

  logic pc_hold_c, pc_redirect_c;
  logic if_id_hold_c, id_ex_hold_c, ex_mem_hold_c;
  logic if_id_flush_c, id_ex_flush_c, ex_mem_flush_c, mem_wb_flush_c;

  logic [1:0]            perf_inc;
  logic [1:0][CNT_W-1:0] perf_val;

  // Hazard decode from the current pipeline snapshot.
  assign rs1_hit   = hz.ID_uses_rs1 && (hz.ID_rs1 == hz.EX_rd);
  assign rs2_hit   = hz.ID_uses_rs2 && (hz.ID_rs2 == hz.EX_rd);
  assign load_use  = hz.EX_mem2reg && hz.EX_reg_wen && (hz.EX_rd != 5'd0) && (rs1_hit || rs2_hit);
  assign redir     = (hz.MEM_is_branch && hz.MEM_cmp_res) || hz.MEM_is_jal || hz.MEM_is_jalr;
  assign mem_stall = hz.MEM_mem_access && !hz.dmem_ready;

  assign active   = rst_n && ((state_reg == ST_RUN) || (state_reg == ST_MEM_WAIT));
  // Once waiting, only dmem_ready ends the stall, whatever MEM_mem_access does.
  assign in_stall = rst_n && (((state_reg == ST_RUN) && mem_stall) ||
                              ((state_reg == ST_MEM_WAIT) && !hz.dmem_ready));

  always_comb begin
    pc_hold_c      = 1'b0;
    pc_redirect_c  = 1'b0;
    if_id_hold_c   = 1'b0;
    id_ex_hold_c   = 1'b0;
    ex_mem_hold_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_flush_c = 1'b0;
    mem_wb_flush_c = 1'b0;

    if (!rst_n || (state_reg == ST_PURGE) || !active) begin
      pc_hold_c      = 1'b1;
      if_id_flush_c  = 1'b1;
      id_ex_flush_c  = 1'b1;
      ex_mem_flush_c = 1'b1;
      mem_wb_flush_c = 1'b1;
    end else if (in_stall) begin
      pc_hold_c      = 1'b1;
      if_id_hold_c   = 1'b1;
      id_ex_hold_c   = 1'b1;
      ex_mem_hold_c  = 1'b1;
      mem_wb_flush_c = 1'b1;
    end else if (redir) begin
      // A redirect also squashes any load-use bubble seen in the same cycle.
      pc_redirect_c  = 1'b1;
      if_id_flush_c  = 1'b1;
      id_ex_flush_c  = 1'b1;
      ex_mem_flush_c = 1'b1;
    end else if (load_use) begin
      pc_hold_c      = 1'b1;
      if_id_hold_c   = 1'b1;
      id_ex_flush_c  = 1'b1;
    end
  end

  always_comb begin
    state_next     = state_reg;
    purge_cnt_next = purge_cnt_reg;
    wait_cnt_next  = 8'd0;
    mem_err_next   = mem_err_reg;

    case (state_reg)
      ST_PURGE: begin
        if (purge_cnt_reg == PURGE_LAST) begin
          state_next     = ST_RUN;
          purge_cnt_next = '0;
        end else begin
          purge_cnt_next = purge_cnt_reg + PW'(1);
        end
      end
      ST_RUN, ST_MEM_WAIT: begin
        state_next = in_stall ? ST_MEM_WAIT : ST_RUN;
      end
      default: begin
        state_next     = ST_PURGE;
        purge_cnt_next = '0;
      end
    endcase

    // The wait counter counts stall cycles of the current access and saturates.
    if (in_stall) begin
      wait_cnt_next = (wait_cnt_reg == TIMEOUT) ? wait_cnt_reg : wait_cnt_reg + 8'd1;
      if (wait_cnt_next == TIMEOUT)
        mem_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_PURGE;
      purge_cnt_reg <= '0;
      wait_cnt_reg  <= 8'd0;
      mem_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      purge_cnt_reg <= purge_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      mem_err_reg   <= mem_err_next;
    end
  end

  // Index 0 counts stalled cycles, index 1 counts redirects taken.
  assign perf_inc[0] = active && pc_hold_c;
  assign perf_inc[1] = active && pc_redirect_c;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (!rst_n)
          cnt_reg <= '0;
        else if (perf_inc[gi])
          cnt_reg <= cnt_reg + CNT_W'(1);
      end
      assign perf_val[gi] = rst_n ? cnt_reg : '0;
    end
  endgenerate

  assign hz.pc_hold      = pc_hold_c;
  assign hz.pc_redirect  = pc_redirect_c;
  assign hz.IF_ID_hold   = if_id_hold_c;
  assign hz.ID_EX_hold   = id_ex_hold_c;
  assign hz.EX_MEM_hold  = ex_mem_hold_c;
  assign hz.IF_ID_flush  = if_id_flush_c;
  assign hz.ID_EX_flush  = id_ex_flush_c;
  assign hz.EX_MEM_flush = ex_mem_flush_c;
  assign hz.MEM_WB_flush = mem_wb_flush_c;
  assign hz.mem_err      = rst_n && mem_err_reg;
  assign hz.stall_cnt    = perf_val[0];
  assign hz.flush_cnt    = perf_val[1];

  hold_flush_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(if_id_hold_c && if_id_flush_c) && !(id_ex_hold_c && id_ex_flush_c) &&
    !(ex_mem_hold_c && ex_mem_flush_c));

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: purge, load-use, redirects, dmem waits, timeout.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 32;

  // {pc_hold, pc_redirect, IF_ID_hold, ID_EX_hold, EX_MEM_hold,
  //  IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush}
  localparam logic [8:0] C_NONE  = 9'b0_0_000_0000;
  localparam logic [8:0] C_PURGE = 9'b1_0_000_1111;
  localparam logic [8:0] C_WAIT  = 9'b1_0_111_0001;
  localparam logic [8:0] C_REDIR = 9'b0_1_000_1110;
  localparam logic [8:0] C_LU    = 9'b1_0_100_0100;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;
  logic [8:0] ctl;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.PURGE_CYCLES(4), .MEM_TIMEOUT(255), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus)
  );

  always #5 clk = ~clk;

  assign ctl = {bus.pc_hold, bus.pc_redirect, bus.IF_ID_hold, bus.ID_EX_hold, bus.EX_MEM_hold,
                bus.IF_ID_flush, bus.ID_EX_flush, bus.EX_MEM_flush, bus.MEM_WB_flush};

  task automatic clear_inputs();
    bus.ID_rs1 = 5'd0; bus.ID_rs2 = 5'd0; bus.ID_uses_rs1 = 1'b0; bus.ID_uses_rs2 = 1'b0;
    bus.EX_rd = 5'd0; bus.EX_mem2reg = 1'b0; bus.EX_reg_wen = 1'b0;
    bus.MEM_is_branch = 1'b0; bus.MEM_cmp_res = 1'b0; bus.MEM_is_jal = 1'b0;
    bus.MEM_is_jalr = 1'b0; bus.MEM_mem_access = 1'b0; bus.dmem_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    #1;
    checks++; if (ctl !== C_PURGE) begin errors++; $display("FAIL reset_ctl got %b want %b", ctl, C_PURGE); end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ctl !== C_PURGE) begin errors++; $display("FAIL purge_ctl[%0d] got %b want %b", i, ctl, C_PURGE); end
      tick();
    end
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL post_purge_ctl got %b want %b", ctl, C_NONE); end
    checks++; if (bus.stall_cnt !== 0 || bus.flush_cnt !== 0 || bus.mem_err !== 1'b0) begin
      errors++; $display("FAIL reset_state got stall=%0d flush=%0d err=%b want 0/0/0", bus.stall_cnt, bus.flush_cnt, bus.mem_err);
    end
    $display("reset: purge done ctl=%b", ctl);
  endtask

  task automatic test_load_use();
    bus.EX_mem2reg = 1'b1; bus.EX_reg_wen = 1'b1; bus.EX_rd = 5'd5; bus.ID_rs2 = 5'd5; bus.ID_uses_rs2 = 1'b1;
    #1;
    checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs2 got %b want %b", ctl, C_LU); end
    tick(); exp_stall++;
    clear_inputs();
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL lu_release got %b want %b", ctl, C_NONE); end
    checks++; if (bus.stall_cnt !== CNT_W'(exp_stall)) begin errors++; $display("FAIL lu_stall_cnt got %0d want %0d", bus.stall_cnt, exp_stall); end
    bus.EX_mem2reg = 1'b1; bus.EX_reg_wen = 1'b1; bus.EX_rd = 5'd0; bus.ID_rs2 = 5'd0; bus.ID_uses_rs2 = 1'b1;
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL lu_x0 got %b want %b", ctl, C_NONE); end
    tick();
    bus.EX_rd = 5'd7; bus.ID_rs1 = 5'd7; bus.ID_uses_rs1 = 1'b0; bus.ID_uses_rs2 = 1'b0;
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL lu_unused_rs1 got %b want %b", ctl, C_NONE); end
    bus.ID_uses_rs1 = 1'b1;
    #1;
    checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs1 got %b want %b", ctl, C_LU); end
    tick(); exp_stall++;
    clear_inputs();
    #1;
    checks++; if (bus.stall_cnt !== CNT_W'(exp_stall)) begin errors++; $display("FAIL lu2_stall_cnt got %0d want %0d", bus.stall_cnt, exp_stall); end
    $display("load_use: stall_cnt=%0d", bus.stall_cnt);
  endtask

  task automatic test_branch();
    bus.MEM_is_branch = 1'b1; bus.MEM_cmp_res = 1'b1;
    #1;
    checks++; if (ctl !== C_REDIR) begin errors++; $display("FAIL br_taken got %b want %b", ctl, C_REDIR); end
    tick(); exp_flush++;
    bus.MEM_cmp_res = 1'b0;
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL br_not_taken got %b want %b", ctl, C_NONE); end
    checks++; if (bus.flush_cnt !== CNT_W'(exp_flush)) begin errors++; $display("FAIL br_flush_cnt got %0d want %0d", bus.flush_cnt, exp_flush); end
    tick();
    clear_inputs();
    bus.MEM_is_jal = 1'b1;
    #1;
    checks++; if (ctl !== C_REDIR) begin errors++; $display("FAIL jal got %b want %b", ctl, C_REDIR); end
    tick(); exp_flush++;
    clear_inputs();
    #1;
    checks++; if (bus.flush_cnt !== CNT_W'(exp_flush) || bus.stall_cnt !== CNT_W'(exp_stall)) begin
      errors++; $display("FAIL jal_counts got flush=%0d stall=%0d want %0d/%0d", bus.flush_cnt, bus.stall_cnt, exp_flush, exp_stall);
    end
    $display("branch: flush_cnt=%0d", bus.flush_cnt);
  endtask

  task automatic test_back_to_back();
    bus.MEM_is_branch = 1'b1; bus.MEM_cmp_res = 1'b1;
    bus.EX_mem2reg = 1'b1; bus.EX_reg_wen = 1'b1; bus.EX_rd = 5'd9; bus.ID_rs1 = 5'd9; bus.ID_uses_rs1 = 1'b1;
    #1;
    checks++; if (ctl !== C_REDIR) begin errors++; $display("FAIL redir_vs_lu got %b want %b", ctl, C_REDIR); end
    tick(); exp_flush++;
    bus.MEM_is_branch = 1'b0; bus.MEM_cmp_res = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (ctl !== C_LU) begin errors++; $display("FAIL b2b_lu[%0d] got %b want %b", i, ctl, C_LU); end
      tick(); exp_stall++;
    end
    clear_inputs();
    #1;
    checks++; if (bus.flush_cnt !== CNT_W'(exp_flush) || bus.stall_cnt !== CNT_W'(exp_stall)) begin
      errors++; $display("FAIL b2b_counts got flush=%0d stall=%0d want %0d/%0d", bus.flush_cnt, bus.stall_cnt, exp_flush, exp_stall);
    end
    $display("back_to_back: flush_cnt=%0d stall_cnt=%0d", bus.flush_cnt, bus.stall_cnt);
  endtask

  task automatic test_mem_wait();
    bus.MEM_mem_access = 1'b1; bus.dmem_ready = 1'b1;
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL mem_ready_now got %b want %b", ctl, C_NONE); end
    tick();
    bus.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl !== C_WAIT) begin errors++; $display("FAIL mem_wait[%0d] got %b want %b", i, ctl, C_WAIT); end
      tick(); exp_stall++;
    end
    bus.dmem_ready = 1'b1;
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL mem_release got %b want %b", ctl, C_NONE); end
    tick();
    clear_inputs();
    #1;
    checks++; if (bus.stall_cnt !== CNT_W'(exp_stall)) begin errors++; $display("FAIL mem_stall_cnt got %0d want %0d", bus.stall_cnt, exp_stall); end
    $display("mem_wait: stall_cnt=%0d", bus.stall_cnt);
  endtask

  task automatic test_wait_jalr();
    bus.MEM_is_jalr = 1'b1; bus.MEM_mem_access = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (ctl !== C_WAIT) begin errors++; $display("FAIL jalr_wait[%0d] got %b want %b", i, ctl, C_WAIT); end
      tick(); exp_stall++;
    end
    bus.dmem_ready = 1'b1;
    #1;
    checks++; if (ctl !== C_REDIR) begin errors++; $display("FAIL jalr_complete got %b want %b", ctl, C_REDIR); end
    tick(); exp_flush++;
    clear_inputs();
    #1;
    checks++; if (bus.flush_cnt !== CNT_W'(exp_flush) || bus.stall_cnt !== CNT_W'(exp_stall) || bus.mem_err !== 1'b0) begin
      errors++; $display("FAIL jalr_counts got flush=%0d stall=%0d err=%b want %0d/%0d/0", bus.flush_cnt, bus.stall_cnt, bus.mem_err, exp_flush, exp_stall);
    end
    $display("wait_jalr: flush_cnt=%0d stall_cnt=%0d", bus.flush_cnt, bus.stall_cnt);
  endtask

  task automatic test_timeout();
    bus.MEM_mem_access = 1'b1; bus.dmem_ready = 1'b0;
    // Stall cycle n sees a wait count of n-1, so mem_err appears in stall cycle 256.
    for (int n = 1; n <= 300; n++) begin
      #1;
      if (n == 255) begin
        checks++; if (bus.mem_err !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0", bus.mem_err); end
      end
      if (n == 256) begin
        checks++; if (bus.mem_err !== 1'b1) begin errors++; $display("FAIL timeout_hit got %b want 1", bus.mem_err); end
      end
      if (n == 300) begin
        checks++; if (ctl !== C_WAIT) begin errors++; $display("FAIL timeout_still_stalled got %b want %b", ctl, C_WAIT); end
      end
      tick(); exp_stall++;
    end
    bus.dmem_ready = 1'b1;
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL timeout_release got %b want %b", ctl, C_NONE); end
    tick();
    clear_inputs();
    #1;
    checks++; if (bus.mem_err !== 1'b1 || bus.stall_cnt !== CNT_W'(exp_stall)) begin
      errors++; $display("FAIL timeout_sticky got err=%b stall=%0d want 1/%0d", bus.mem_err, bus.stall_cnt, exp_stall);
    end
    $display("timeout: mem_err=%b stall_cnt=%0d", bus.mem_err, bus.stall_cnt);
  endtask

  task automatic test_reset_mid_wait();
    bus.MEM_mem_access = 1'b1; bus.dmem_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (ctl !== C_PURGE || bus.mem_err !== 1'b0) begin
      errors++; $display("FAIL rst_in_wait got ctl=%b err=%b want %b/0", ctl, bus.mem_err, C_PURGE);
    end
    tick();
    rst_n = 1'b1;
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ctl !== C_PURGE) begin errors++; $display("FAIL repurge[%0d] got %b want %b", i, ctl, C_PURGE); end
      tick();
    end
    #1;
    checks++; if (ctl !== C_NONE || bus.mem_err !== 1'b0 || bus.stall_cnt !== 0 || bus.flush_cnt !== 0) begin
      errors++; $display("FAIL repurge_state got ctl=%b err=%b stall=%0d flush=%0d want 0", ctl, bus.mem_err, bus.stall_cnt, bus.flush_cnt);
    end
    $display("reset_mid_wait: ctl=%b mem_err=%b", ctl, bus.mem_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_back_to_back();
    test_mem_wait();
    test_wait_jalr();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
